// File: rtl/one_of_n_plus_3_dispatch_pkg.sv
// Shared constants and helpers for the 1-to-6 stream dispatcher.
package one_of_n_plus_3_dispatch_pkg;

  localparam int unsigned NUM_OUT = 6;
  localparam int unsigned SEL_W   = 3;

  localparam logic [SEL_W-1:0] SEL_NULL_6 = 3'd6;
  localparam logic [SEL_W-1:0] SEL_NULL_7 = 3'd7;

  // True when the select code addresses a discard destination.
  function automatic logic is_null_sel(input logic [SEL_W-1:0] sel);
    return (sel == SEL_NULL_6) || (sel == SEL_NULL_7);
  endfunction

endpackage

// File: rtl/one_of_n_plus_3_dispatch_if.sv
// Input stream, six output channels and drop counter of the dispatcher.
interface one_of_n_plus_3_dispatch_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
);
  import one_of_n_plus_3_dispatch_pkg::*;

  logic [WIDTH-1:0]      in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_val;
  logic                  in_rdy;
  logic [WIDTH-1:0]      out0_data;
  logic [WIDTH-1:0]      out1_data;
  logic [WIDTH-1:0]      out2_data;
  logic [WIDTH-1:0]      out3_data;
  logic [WIDTH-1:0]      out4_data;
  logic [WIDTH-1:0]      out5_data;
  logic [NUM_OUT-1:0]    out_val;
  logic [NUM_OUT-1:0]    out_rdy;
  logic [DROP_CNT_W-1:0] drop_cnt;

  // Producer and consumers side.
  modport master (
    output in_data, in_sel, in_val, out_rdy,
    input  in_rdy, out0_data, out1_data, out2_data, out3_data, out4_data,
           out5_data, out_val, drop_cnt
  );

  // Dispatcher side.
  modport slave (
    input  in_data, in_sel, in_val, out_rdy,
    output in_rdy, out0_data, out1_data, out2_data, out3_data, out4_data,
           out5_data, out_val, drop_cnt
  );

endinterface

// File: rtl/one_of_n_plus_3_dispatch_slot.sv
// One-entry holding register with valid/ready handshake for one channel.
module dispatch_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] data,
  output logic             val,
  output logic             can_load
);

  // Empty, or being emptied this cycle, so a new word may land.
  assign can_load = !val || deq_rdy;

  // Load wins over dequeue; data is kept after dequeue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val  <= 1'b0;
      data <= '0;
    end else if (load) begin
      val  <= 1'b1;
      data <= load_data;
    end else if (val && deq_rdy) begin
      val  <= 1'b0;
    end
  end

endmodule

// File: rtl/one_of_n_plus_3_dispatch.sv
// Registered 1-to-6 dispatcher; select codes 6/7 discard and count the word.
module one_of_n_plus_3_dispatch #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  one_of_n_plus_3_dispatch_if.slave  bus
);
  import one_of_n_plus_3_dispatch_pkg::*;

  logic [NUM_OUT-1:0]    load;
  logic [NUM_OUT-1:0]    can_load;
  logic [NUM_OUT-1:0]    slot_val;
  logic [WIDTH-1:0]      slot_data [NUM_OUT];
  logic                  rdy;
  logic                  sel_null;
  logic                  accept;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Select decode, ready mux over the addressed slot, per-slot load strobes.
  always_comb begin
    rdy      = 1'b1;
    load     = '0;
    sel_null = is_null_sel(bus.in_sel);
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (bus.in_sel == SEL_W'(k)) rdy = can_load[k];
    end
    accept = bus.in_val && rdy;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      load[k] = accept && (bus.in_sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    dispatch_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (bus.in_data),
      .deq_rdy   (bus.out_rdy[k]),
      .data      (slot_data[k]),
      .val       (slot_val[k]),
      .can_load  (can_load[k])
    );
  end

  // Saturating count of words sent to null destinations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && sel_null && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign bus.in_rdy    = rdy;
  assign bus.out_val   = slot_val;
  assign bus.out0_data = slot_data[0];
  assign bus.out1_data = slot_data[1];
  assign bus.out2_data = slot_data[2];
  assign bus.out3_data = slot_data[3];
  assign bus.out4_data = slot_data[4];
  assign bus.out5_data = slot_data[5];
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_one_of_n_plus_3_dispatch.sv
// Scoreboard bench for the 1-to-6 dispatcher plus a 2-bit drop counter instance.
module tb_one_of_n_plus_3_dispatch;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];
  logic [7:0] q4[$];
  logic [7:0] q5[$];

  one_of_n_plus_3_dispatch_if #(.WIDTH(8), .DROP_CNT_W(16)) b ();
  one_of_n_plus_3_dispatch_if #(.WIDTH(8), .DROP_CNT_W(2))  b2 ();

  one_of_n_plus_3_dispatch #(.WIDTH(8), .DROP_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  one_of_n_plus_3_dispatch #(.WIDTH(8), .DROP_CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input int k, input logic [7:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      3: q3.push_back(d);
      4: q4.push_back(d);
      default: q5.push_back(d);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      4: return q4.size();
      default: return q5.size();
    endcase
  endfunction

  function automatic logic [7:0] pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      3: return q3.pop_front();
      4: return q4.pop_front();
      default: return q5.pop_front();
    endcase
  endfunction

  function automatic logic [7:0] out_data(input int k);
    case (k)
      0: return b.out0_data;
      1: return b.out1_data;
      2: return b.out2_data;
      3: return b.out3_data;
      4: return b.out4_data;
      default: return b.out5_data;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every dequeue handshake must deliver the next expected word of that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 6; k++) begin
        if (b.out_val[k] && b.out_rdy[k]) begin
          if (qsize(k) == 0) begin
            chk($sformatf("deq_unexpected_ch%0d", k), 32'(out_data(k)), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("deq_data_ch%0d", k), 32'(out_data(k)), 32'(pop(k)));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    b.in_val = 1'b1; b.in_sel = 3'd2; b.in_data = 8'hAA; b.out_rdy = '0;
    b2.in_val = 1'b0; b2.in_sel = 3'd6; b2.in_data = 8'h00; b2.out_rdy = '0;

    // Reset with an accept pending: it must be discarded.
    cyc(); cyc();
    rst_n = 1'b1;
    b.in_val = 1'b0;
    chk("rst_out_val", 32'(b.out_val), 32'h0);
    chk("rst_out2_data", 32'(b.out2_data), 32'h0);
    chk("rst_drop_cnt", 32'(b.drop_cnt), 32'h0);

    // Single route, then back-pressure, then load+dequeue in one cycle.
    b.in_sel = 3'd3; b.in_data = 8'h5C; b.in_val = 1'b1;
    #1 chk("route_rdy_empty", 32'(b.in_rdy), 32'h1);
    push(3, 8'h5C);
    cyc();
    b.in_data = 8'h11;
    #1 chk("route_rdy_full", 32'(b.in_rdy), 32'h0);
    chk("route_out_val", 32'(b.out_val), 32'h08);
    chk("route_out3_data", 32'(b.out3_data), 32'h5C);
    cyc();
    chk("route_stall_hold", 32'(b.out3_data), 32'h5C);
    b.out_rdy = 6'b001000;
    #1 chk("route_rdy_deq", 32'(b.in_rdy), 32'h1);
    push(3, 8'h11);
    cyc();
    b.in_val = 1'b0; b.out_rdy = '0;
    chk("route_reload_val", 32'(b.out_val), 32'h08);
    chk("route_reload_data", 32'(b.out3_data), 32'h11);

    // Null drops alternating 6/7; second instance saturates its 2-bit counter.
    b.in_val = 1'b1; b2.in_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b.in_sel  = (i % 2 == 1) ? 3'd7 : 3'd6;
      b2.in_sel = b.in_sel;
      b.in_data = 8'(i);
      #1 chk($sformatf("null_rdy_%0d", i), 32'(b.in_rdy), 32'h1);
      cyc();
      if (i == 2) chk("sat_preload", 32'(b2.drop_cnt), 32'h3);
    end
    b.in_val = 1'b0; b2.in_val = 1'b0;
    chk("null_out_val", 32'(b.out_val), 32'h08);
    chk("null_drop_cnt", 32'(b.drop_cnt), 32'h5);
    chk("sat_drop_cnt", 32'(b2.drop_cnt), 32'h3);
    chk("sat_out_val", 32'(b2.out_val), 32'h0);

    // Drain channel 3 before filling all channels.
    b.out_rdy = 6'b001000;
    cyc();
    b.out_rdy = '0;
    chk("drain3_out_val", 32'(b.out_val), 32'h0);

    // Independent channels filled back to back with no consumers.
    for (int k = 0; k < 6; k++) begin
      b.in_sel = 3'(k); b.in_data = 8'h20 + 8'(k); b.in_val = 1'b1;
      #1 chk($sformatf("fill_rdy_%0d", k), 32'(b.in_rdy), 32'h1);
      push(k, 8'h20 + 8'(k));
      cyc();
    end
    b.in_val = 1'b0;
    chk("fill_out_val", 32'(b.out_val), 32'h3F);

    // Null word still flows while every channel is full.
    b.in_sel = 3'd6; b.in_data = 8'h66; b.in_val = 1'b1;
    #1 chk("full_null_rdy", 32'(b.in_rdy), 32'h1);
    cyc();
    chk("full_null_cnt", 32'(b.drop_cnt), 32'h6);
    b.in_sel = 3'd4; b.in_data = 8'h44;
    #1 chk("full_ch4_rdy", 32'(b.in_rdy), 32'h0);
    cyc(); cyc();
    b.in_val = 1'b0;
    chk("full_ch4_hold", 32'(b.out4_data), 32'h24);
    chk("full_out_val", 32'(b.out_val), 32'h3F);

    // Multi-dequeue of channels 0, 2, 5 in one cycle.
    b.out_rdy = 6'b100101;
    cyc();
    b.out_rdy = '0;
    chk("mdeq_out_val", 32'(b.out_val), 32'h1A);
    chk("mdeq_out0_data", 32'(b.out0_data), 32'h20);
    chk("mdeq_out2_data", 32'(b.out2_data), 32'h22);
    chk("mdeq_out5_data", 32'(b.out5_data), 32'h25);

    // Streaming ten words into channel 1 with its consumer always ready.
    b.out_rdy = 6'b000010;
    for (int i = 0; i < 10; i++) begin
      b.in_sel = 3'd1; b.in_data = 8'(i); b.in_val = 1'b1;
      #1 chk($sformatf("stream_rdy_%0d", i), 32'(b.in_rdy), 32'h1);
      push(1, 8'(i));
      cyc();
      chk($sformatf("stream_data_%0d", i), 32'(b.out1_data), 32'(i));
    end
    b.in_val = 1'b0;
    cyc();
    b.out_rdy = '0;
    chk("stream_done_val", 32'(b.out_val), 32'h18);

    // Final drain: everything outstanding must come out exactly once.
    b.out_rdy = 6'b111111;
    cyc();
    b.out_rdy = '0;
    chk("final_out_val", 32'(b.out_val), 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("final_q%0d_empty", k), 32'(qsize(k)), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/one_of_n_plus_3_dispatch.md
# one_of_n_plus_3_dispatch

Registered 1-to-6 stream dispatcher: the transmit-side counterpart of the 6:1 select mux. One input stream carries data plus a 3-bit destination select. Each word is steered into one of six output channels, each with a one-entry holding register and a valid/ready handshake. Select codes 6 and 7 are null destinations: the word is consumed, discarded and counted.

## Interface
Parameters:
- WIDTH, 8, data width of input and every output channel
- DROP_CNT_W, 16, width of the null-destination drop counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  WIDTH  input word
- in_sel  in  3  destination: 0..5 = channel, 6/7 = null
- in_val  in  1  input word valid
- in_rdy  out  1  block can accept input this cycle
- out0_data .. out5_data  out  WIDTH each  channel holding-register contents
- out_val  out  6  bit k = channel k holds a word
- out_rdy  in  6  bit k = consumer k takes the word this cycle
- drop_cnt  out  DROP_CNT_W  count of words sent to null destinations, saturating

## Operation
- Accept: in_val & in_rdy in a cycle.
- in_rdy for sel k in 0..5 = !out_val[k] | out_rdy[k]. This is a combinational path from out_rdy through in_rdy.
- in_rdy for sel 6/7 = 1. Null words are never stalled.
- Accept to channel k: outk_data <= in_data and out_val[k] <= 1 at the next edge.
- Dequeue on channel k: out_val[k] & out_rdy[k]. Clears out_val[k] at the next edge unless the same cycle also accepts a word to k. In that case the register reloads and out_val[k] stays 1.
- outk_data holds its last value after dequeue. It is not zeroed.
- At most one channel is loaded per cycle. Any number of channels may dequeue in the same cycle.
- out_rdy[k] while out_val[k]=0 is ignored.
- Null accept (sel 6/7): no channel changes. drop_cnt increments by 1 and saturates at all-ones.
- Upstream rule: in_data and in_sel stay stable while in_val & !in_rdy. The block does not check this.
- Reset (rst_n=0 at an edge): out_val=0, all outk_data=0, drop_cnt=0.
  - in_rdy follows its combinational rule during reset. Any accept in a reset cycle is discarded.
  - Reset mid-stream drops held words silently.

## Timing
- Latency: 1 cycle from accept to out_val[k]=1.
- Throughput: 1 word/cycle to one channel if the consumer holds out_rdy=1. 1 word/cycle aggregate across channels.
- Back-pressure: channel k full with out_rdy[k]=0 stalls only inputs addressed to k. in_rdy is 0 for that sel only.
- drop_cnt is updated one edge after the null accept.

## Structure
- Shared package: NUM_OUT=6, SEL_W=3, SEL_NULL_6=3'd6, SEL_NULL_7=3'd7.
- Sub-module dispatch_slot, instantiated 6×.
  - Holds WIDTH data and a valid bit.
  - Inputs: load, load_data, deq_rdy.
  - Outputs: data, val, can_load.
- The top level contains:
  - sel decode
  - in_rdy mux over can_load
  - the drop counter

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_val=1, sel=2, data=8'hAA. Required: out_val=0, out2_data=0, drop_cnt=0 after release.
- Single route: sel=3, data=8'h5C accepted, out_rdy=0. Required next cycle: out_val=6'b001000, out3_data=8'h5C. Then sel=3, data=8'h11 sees in_rdy=0. Raise out_rdy[3]: the 8'h11 accept and the dequeue occur in the same cycle, out3_data=8'h11 and out_val[3] stays 1.
- Independent channels: out_rdy=0, words to sel 0,1,2,3,4,5 on consecutive cycles. Required:
  - all six accepted
  - out_val=6'b111111
  - a seventh word to sel 4 stalls while a word to sel 6 is accepted
- Null drop: 5 words with sel alternating 6/7. Required: no out_val change, drop_cnt=5. With DROP_CNT_W=2, preload by 3 drops then 2 more: drop_cnt holds 2'b11.
- Streaming: out_rdy[1]=1 constant, 10 back-to-back words to sel 1 with data 0..9. Required:
  - in_rdy=1 every cycle
  - out1_data sequence 0..9, one per cycle, 1-cycle latency
- Multi-dequeue: channels 0,2,5 full, out_rdy=6'b100101 in one cycle. Required: all three out_val bits clear next cycle, out0_data/out2_data/out5_data unchanged.
